// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : midi_pkg
// Description : Shared MIDI status-class constants, parser state encoding and
//               the status-to-data-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package midi_pkg;

    // Status-class boundaries
    localparam logic [7:0] CH_MIN   = 8'h80;
    localparam logic [7:0] SYSEX    = 8'hF0;
    localparam logic [7:0] EOX      = 8'hF7;
    localparam logic [7:0] TUNE_REQ = 8'hF6;
    localparam logic [7:0] RT_MIN   = 8'hF8;

    // Parser state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_D1 = 2'd1;
    localparam logic [1:0] ST_WAIT_D2 = 2'd2;
    localparam logic [1:0] ST_SYSEX   = 2'd3;

    // Number of data bytes that follow a status byte (0 for anything that
    // does not open a data-carrying message).
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd0;
        if (status >= CH_MIN && status < SYSEX) begin
            if (status[7:4] == 4'hC || status[7:4] == 4'hD)
                len = 2'd1;
            else
                len = 2'd2;
        end else begin
            case (status)
                8'hF1, 8'hF3: len = 2'd1;
                8'hF2:        len = 2'd2;
                default:      len = 2'd0;
            endcase
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_status_decode.sv
`default_nettype none
// ============================================================================
// Module      : midi_status_decode
// Description : Combinational classification of one MIDI byte.
// Revision    : 1.0 - initial release
// ============================================================================
module midi_status_decode
    import midi_pkg::*;
(
    input  logic [7:0] data_byte,
    output logic       is_data,
    output logic       is_channel,
    output logic       is_rt,
    output logic       is_sysex,
    output logic       is_eox,
    output logic [1:0] data_len
);

    // Byte class and expected payload length
    always_comb begin
        is_data    = ~data_byte[7];
        is_channel = (data_byte >= CH_MIN) && (data_byte < SYSEX);
        is_rt      = (data_byte >= RT_MIN);
        is_sysex   = (data_byte == SYSEX);
        is_eox     = (data_byte == EOX);
        data_len   = midi_data_len(data_byte);
    end

endmodule
`default_nettype wire

// File: rtl/midi_msg_parser.sv
`default_nettype none
// ============================================================================
// Module      : midi_msg_parser
// Description : Assembles complete MIDI messages from a byte stream, with
//               running status, real-time pass-through and SysEx skipping.
// Revision    : 1.0 - initial release
// ============================================================================
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int RUNNING_STATUS_EN = 1,
    parameter int ERR_W             = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       midi_byte,
    input  logic             byte_ready,
    output logic             msg_valid,
    output logic [7:0]       msg_status,
    output logic [6:0]       msg_data1,
    output logic [6:0]       msg_data2,
    output logic [1:0]       msg_len,
    output logic             rt_valid,
    output logic [7:0]       rt_byte,
    output logic [ERR_W-1:0] err_count
);

    logic       w_is_data;
    logic       w_is_channel;
    logic       w_is_rt;
    logic       w_is_sysex;
    logic       w_is_eox;
    logic [1:0] w_len;

    midi_status_decode u_decode (
        .data_byte  (midi_byte),
        .is_data    (w_is_data),
        .is_channel (w_is_channel),
        .is_rt      (w_is_rt),
        .is_sysex   (w_is_sysex),
        .is_eox     (w_is_eox),
        .data_len   (w_len)
    );

    logic [1:0] r_state;
    logic [7:0] r_cur_status;
    logic [6:0] r_d1;
    logic       r_rs_valid;
    logic [7:0] r_rs_status;

    logic [1:0] w_next_state;
    logic [7:0] w_next_cur;
    logic [6:0] w_next_d1;
    logic       w_next_rs_valid;
    logic [7:0] w_next_rs_status;
    logic       w_err_inc;
    logic       w_emit;
    logic [7:0] w_emit_status;
    logic [6:0] w_emit_d1;
    logic [6:0] w_emit_d2;
    logic [1:0] w_emit_len;

    // Next-state, message-emit and error decisions for one non-real-time byte
    always_comb begin
        w_next_state     = r_state;
        w_next_cur       = r_cur_status;
        w_next_d1        = r_d1;
        w_next_rs_valid  = r_rs_valid;
        w_next_rs_status = r_rs_status;
        w_err_inc        = 1'b0;
        w_emit           = 1'b0;
        w_emit_status    = r_cur_status;
        w_emit_d1        = 7'd0;
        w_emit_d2        = 7'd0;
        w_emit_len       = 2'd0;

        if (byte_ready && !w_is_rt) begin
            if (w_is_data) begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_rs_valid) begin
                            w_next_cur = r_rs_status;
                            w_next_d1  = midi_byte[6:0];
                            if (midi_data_len(r_rs_status) == 2'd1) begin
                                w_emit        = 1'b1;
                                w_emit_status = r_rs_status;
                                w_emit_d1     = midi_byte[6:0];
                                w_emit_len    = 2'd1;
                            end else begin
                                w_next_state = ST_WAIT_D2;
                            end
                        end else begin
                            w_err_inc = 1'b1;
                        end
                    end
                    ST_WAIT_D1: begin
                        w_next_d1 = midi_byte[6:0];
                        if (midi_data_len(r_cur_status) == 2'd1) begin
                            w_emit       = 1'b1;
                            w_emit_d1    = midi_byte[6:0];
                            w_emit_len   = 2'd1;
                            w_next_state = ST_IDLE;
                        end else begin
                            w_next_state = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        w_emit       = 1'b1;
                        w_emit_d1    = r_d1;
                        w_emit_d2    = midi_byte[6:0];
                        w_emit_len   = 2'd2;
                        w_next_state = ST_IDLE;
                    end
                    default: ;  // SysEx payload is discarded
                endcase
            end else if (r_state == ST_SYSEX && w_is_eox) begin
                w_next_state = ST_IDLE;
            end else begin
                // A status byte cuts short any partial message; a new 0xF0
                // inside SysEx simply restarts it without counting an error.
                if (r_state == ST_WAIT_D1 || r_state == ST_WAIT_D2)
                    w_err_inc = 1'b1;
                if (r_state == ST_SYSEX && !w_is_sysex)
                    w_err_inc = 1'b1;

                w_next_state = ST_IDLE;
                if (!w_is_channel)
                    w_next_rs_valid = 1'b0;

                if (w_is_sysex) begin
                    w_next_state = ST_SYSEX;
                end else if (w_is_channel) begin
                    w_next_cur   = midi_byte;
                    w_next_state = ST_WAIT_D1;
                    if (RUNNING_STATUS_EN != 0) begin
                        w_next_rs_valid  = 1'b1;
                        w_next_rs_status = midi_byte;
                    end
                end else if (w_len != 2'd0) begin
                    w_next_cur   = midi_byte;
                    w_next_state = ST_WAIT_D1;
                end else if (midi_byte == TUNE_REQ) begin
                    w_emit        = 1'b1;
                    w_emit_status = midi_byte;
                end
            end
        end
    end

    // Parser state, running status and partial-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cur_status <= 8'd0;
            r_d1        <= 7'd0;
            r_rs_valid  <= 1'b0;
            r_rs_status <= 8'd0;
        end else begin
            r_state     <= w_next_state;
            r_cur_status <= w_next_cur;
            r_d1        <= w_next_d1;
            r_rs_valid  <= w_next_rs_valid;
            r_rs_status <= w_next_rs_status;
        end
    end

    // Message output strobe and held message fields
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_valid  <= 1'b0;
            msg_status <= 8'd0;
            msg_data1  <= 7'd0;
            msg_data2  <= 7'd0;
            msg_len    <= 2'd0;
        end else begin
            msg_valid <= w_emit;
            if (w_emit) begin
                msg_status <= w_emit_status;
                msg_data1  <= w_emit_d1;
                msg_data2  <= w_emit_d2;
                msg_len    <= w_emit_len;
            end
        end
    end

    // Real-time bytes bypass the parser entirely
    always_ff @(posedge clk) begin
        if (rst) begin
            rt_valid <= 1'b0;
            rt_byte  <= 8'd0;
        end else begin
            rt_valid <= byte_ready && w_is_rt;
            if (byte_ready && w_is_rt)
                rt_byte <= midi_byte;
        end
    end

    // Saturating error counter
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if (w_err_inc && (err_count != {ERR_W{1'b1}}))
            err_count <= err_count + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_midi_msg_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_msg_parser
// Description : Self-checking bench for midi_msg_parser with directed
//               scenarios and a randomized byte stream against a message-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_msg_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] midi_byte;
    logic       byte_ready;
    logic       msg_valid;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;
    logic [1:0] msg_len;
    logic       rt_valid;
    logic [7:0] rt_byte;
    logic [7:0] err_count;

    always #10 clk = ~clk;

    midi_msg_parser #(
        .RUNNING_STATUS_EN (1),
        .ERR_W             (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .midi_byte  (midi_byte),
        .byte_ready (byte_ready),
        .msg_valid  (msg_valid),
        .msg_status (msg_status),
        .msg_data1  (msg_data1),
        .msg_data2  (msg_data2),
        .msg_len    (msg_len),
        .rt_valid   (rt_valid),
        .rt_byte    (rt_byte),
        .err_count  (err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending message as a status plus a list of data bytes
    logic [7:0] m_pend_status;
    logic [6:0] m_pend_data[$];
    logic [7:0] m_rs;
    bit         m_sysex;
    int         m_err;

    logic       exp_mv;
    logic [7:0] exp_status;
    logic [6:0] exp_d1, exp_d2;
    logic [1:0] exp_len;
    logic       exp_rtv;
    logic [7:0] exp_rtb;

    logic       obs_mv, obs_mv_after, obs_rtv, obs_rtv_after;
    logic [7:0] obs_status, obs_rtb, obs_err;
    logic [6:0] obs_d1, obs_d2;
    logic [1:0] obs_len;
    int         cnt_msg, cnt_rt;

    function automatic int need_len(input logic [7:0] s);
        if (s >= 8'h80 && s < 8'hF0)
            return (s >= 8'hC0 && s < 8'hE0) ? 1 : 2;
        case (s)
            8'hF1, 8'hF3: return 1;
            8'hF2:        return 2;
            default:      return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend_status = 8'h00;
        m_pend_data.delete();
        m_rs    = 8'h00;
        m_sysex = 1'b0;
        m_err   = 0;
        exp_rtb = 8'h00;
        exp_mv  = 1'b0;
        exp_rtv = 1'b0;
    endtask

    task automatic model_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_emit(input logic [7:0] s);
        int n;
        n = m_pend_data.size();
        exp_mv     = 1'b1;
        exp_status = s;
        exp_len    = n[1:0];
        exp_d1     = (n >= 1) ? m_pend_data[0] : 7'd0;
        exp_d2     = (n >= 2) ? m_pend_data[1] : 7'd0;
        m_pend_status = 8'h00;
        m_pend_data.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_mv  = 1'b0;
        exp_rtv = 1'b0;
        if (b >= 8'hF8) begin
            exp_rtv = 1'b1;
            exp_rtb = b;
        end else if (b < 8'h80) begin
            if (!m_sysex) begin
                if (m_pend_status == 8'h00 && m_rs != 8'h00)
                    m_pend_status = m_rs;
                if (m_pend_status == 8'h00) begin
                    model_err();
                end else begin
                    m_pend_data.push_back(b[6:0]);
                    if (m_pend_data.size() == need_len(m_pend_status))
                        model_emit(m_pend_status);
                end
            end
        end else if (m_sysex && b == 8'hF7) begin
            m_sysex = 1'b0;
        end else begin
            if (m_pend_status != 8'h00) model_err();
            if (m_sysex && b != 8'hF0) model_err();
            m_pend_status = 8'h00;
            m_pend_data.delete();
            m_sysex = (b == 8'hF0);
            if (b < 8'hF0) begin
                m_rs = b;
                m_pend_status = b;
            end else begin
                m_rs = 8'h00;
                if (need_len(b) > 0)
                    m_pend_status = b;
                else if (b == 8'hF6)
                    model_emit(b);
            end
        end
    endtask

    // Called at a negedge; returns at a negedge after one idle cycle.
    task automatic drive_byte(input logic [7:0] b);
        midi_byte  = b;
        byte_ready = 1'b1;
        model_byte(b);
        @(negedge clk);
        byte_ready = 1'b0;
        midi_byte  = 8'($urandom);
        obs_mv = msg_valid;  obs_status = msg_status; obs_d1 = msg_data1;
        obs_d2 = msg_data2;  obs_len = msg_len;        obs_rtv = rt_valid;
        obs_rtb = rt_byte;   obs_err = err_count;
        @(negedge clk);
        obs_mv_after  = msg_valid;
        obs_rtv_after = rt_valid;
        cnt_msg += int'(obs_mv) + int'(obs_mv_after);
        cnt_rt  += int'(obs_rtv) + int'(obs_rtv_after);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        byte_ready = 1'b0;
        midi_byte  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cnt_msg = 0;
        cnt_rt  = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({msg_valid, msg_status, msg_data1, msg_data2, msg_len, rt_valid, rt_byte, err_count} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {msg_valid, msg_status, msg_data1, msg_data2, msg_len, rt_valid, rt_byte, err_count});
        end
    endtask

    task automatic test_note_running();
        apply_reset();
        drive_byte(8'h90); drive_byte(8'h3C); drive_byte(8'h64);
        n_checks++;
        if ({obs_mv, obs_status, obs_d1, obs_d2, obs_len} !== {1'b1, 8'h90, 7'h3C, 7'h64, 2'd2}) begin
            n_fail++;
            $display("FAIL note_on: got v=%b %h %h %h len=%0d expected 1 90 3c 64 len=2",
                     obs_mv, obs_status, obs_d1, obs_d2, obs_len);
        end
        drive_byte(8'h3E); drive_byte(8'h00);
        n_checks++;
        if ({obs_mv, obs_status, obs_d1, obs_d2, obs_len} !== {1'b1, 8'h90, 7'h3E, 7'h00, 2'd2}) begin
            n_fail++;
            $display("FAIL running_status: got v=%b %h %h %h len=%0d expected 1 90 3e 00 len=2",
                     obs_mv, obs_status, obs_d1, obs_d2, obs_len);
        end
        n_checks++;
        if (cnt_msg !== 2 || obs_err !== 8'd0) begin
            n_fail++;
            $display("FAIL running_counts: got msgs=%0d err=%0d expected msgs=2 err=0", cnt_msg, obs_err);
        end
    endtask

    task automatic test_prog_tune();
        apply_reset();
        drive_byte(8'hC5); drive_byte(8'h07);
        n_checks++;
        if ({obs_mv, obs_status, obs_d1, obs_d2, obs_len} !== {1'b1, 8'hC5, 7'h07, 7'h00, 2'd1}) begin
            n_fail++;
            $display("FAIL prog_change: got v=%b %h %h %h len=%0d expected 1 c5 07 00 len=1",
                     obs_mv, obs_status, obs_d1, obs_d2, obs_len);
        end
        drive_byte(8'hF6);
        n_checks++;
        if ({obs_mv, obs_status, obs_d1, obs_d2, obs_len} !== {1'b1, 8'hF6, 7'h00, 7'h00, 2'd0}) begin
            n_fail++;
            $display("FAIL tune_request: got v=%b %h %h %h len=%0d expected 1 f6 00 00 len=0",
                     obs_mv, obs_status, obs_d1, obs_d2, obs_len);
        end
    endtask

    task automatic test_realtime_interleave();
        apply_reset();
        drive_byte(8'h90); drive_byte(8'hF8); drive_byte(8'h3C);
        drive_byte(8'hFA); drive_byte(8'h64);
        n_checks++;
        if ({obs_mv, obs_status, obs_d1, obs_d2, obs_len} !== {1'b1, 8'h90, 7'h3C, 7'h64, 2'd2}) begin
            n_fail++;
            $display("FAIL rt_interleave_msg: got v=%b %h %h %h len=%0d expected 1 90 3c 64 len=2",
                     obs_mv, obs_status, obs_d1, obs_d2, obs_len);
        end
        n_checks++;
        if (cnt_msg !== 1 || cnt_rt !== 2 || obs_rtb !== 8'hFA || obs_err !== 8'd0) begin
            n_fail++;
            $display("FAIL rt_interleave_counts: got msgs=%0d rts=%0d rt_byte=%h err=%0d expected 1 2 fa 0",
                     cnt_msg, cnt_rt, obs_rtb, obs_err);
        end
    endtask

    task automatic test_sysex();
        apply_reset();
        drive_byte(8'h90); drive_byte(8'h3C); drive_byte(8'h64);
        cnt_msg = 0;
        drive_byte(8'hF0); drive_byte(8'h7E); drive_byte(8'h01);
        drive_byte(8'h02); drive_byte(8'hF7); drive_byte(8'h40);
        n_checks++;
        if (cnt_msg !== 0 || obs_err !== 8'd1) begin
            n_fail++;
            $display("FAIL sysex_skip: got msgs=%0d err=%0d expected msgs=0 err=1", cnt_msg, obs_err);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        drive_byte(8'h90); drive_byte(8'h3C); drive_byte(8'hB0);
        drive_byte(8'h07); drive_byte(8'h7F);
        n_checks++;
        if ({obs_status, obs_d1, obs_d2, obs_len} !== {8'hB0, 7'h07, 7'h7F, 2'd2} || cnt_msg !== 1 || obs_err !== 8'd1) begin
            n_fail++;
            $display("FAIL abort: got %h %h %h len=%0d msgs=%0d err=%0d expected b0 07 7f len=2 msgs=1 err=1",
                     obs_status, obs_d1, obs_d2, obs_len, cnt_msg, obs_err);
        end
    endtask

    task automatic test_reset_mid_msg();
        apply_reset();
        drive_byte(8'h90);
        apply_reset();
        drive_byte(8'h3C);
        n_checks++;
        if (obs_err !== 8'd1 || obs_mv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_first: got err=%0d v=%b expected err=1 v=0", obs_err, obs_mv);
        end
        drive_byte(8'h64);
        n_checks++;
        if (obs_err !== 8'd2 || cnt_msg !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_second: got err=%0d msgs=%0d expected err=2 msgs=0", obs_err, cnt_msg);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 254; i++) drive_byte(8'($urandom_range(0, 127)));
        n_checks++;
        if (obs_err !== 8'd254) begin
            n_fail++;
            $display("FAIL sat_below: got err=%0d expected 254", obs_err);
        end
        for (int i = 0; i < 6; i++) drive_byte(8'($urandom_range(0, 127)));
        n_checks++;
        if (obs_err !== 8'hFF) begin
            n_fail++;
            $display("FAIL sat_hold: got err=%0d expected 255", obs_err);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int sel;
        apply_reset();
        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 50)      b = 8'($urandom_range(8'h00, 8'h7F));
            else if (sel < 82) b = 8'($urandom_range(8'h80, 8'hEF));
            else if (sel < 93) b = 8'($urandom_range(8'hF0, 8'hF7));
            else               b = 8'($urandom_range(8'hF8, 8'hFF));
            drive_byte(b);
            n_checks++;
            if (obs_mv !== exp_mv || obs_mv_after !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_msg_valid[%0d] byte=%h: got %b,%b expected %b,0",
                         i, b, obs_mv, obs_mv_after, exp_mv);
            end
            if (exp_mv) begin
                n_checks++;
                if ({obs_status, obs_d1, obs_d2, obs_len} !== {exp_status, exp_d1, exp_d2, exp_len}) begin
                    n_fail++;
                    $display("FAIL rand_fields[%0d]: got %h %h %h len=%0d expected %h %h %h len=%0d",
                             i, obs_status, obs_d1, obs_d2, obs_len, exp_status, exp_d1, exp_d2, exp_len);
                end
            end
            n_checks++;
            if (obs_rtv !== exp_rtv || obs_rtb !== exp_rtb || obs_rtv_after !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_rt[%0d]: got v=%b b=%h after=%b expected v=%b b=%h after=0",
                         i, obs_rtv, obs_rtb, obs_rtv_after, exp_rtv, exp_rtb);
            end
            n_checks++;
            if (obs_err !== 8'(m_err)) begin
                n_fail++;
                $display("FAIL rand_err[%0d] byte=%h: got %0d expected %0d", i, b, obs_err, m_err);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        byte_ready = 1'b0;
        midi_byte  = 8'h00;
        cnt_msg    = 0;
        cnt_rt     = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_note_running();
        test_prog_tune();
        test_realtime_interleave();
        test_sysex();
        test_abort();
        test_reset_mid_msg();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
